// File: rtl/bj_pkg.sv
// Shared types and constants for the blackjack round controller.
package bj_pkg;

    localparam int SCORE_W_DEF = 5;
    localparam int ACE         = 1;
    localparam int BLACKJACK   = 21;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        DEAL_P1     = 4'd1,
        DEAL_D1     = 4'd2,
        DEAL_P2     = 4'd3,
        DEAL_D2     = 4'd4,
        PLAYER_TURN = 4'd5,
        PLAYER_HIT  = 4'd6,
        DEALER_TURN = 4'd7,
        DEALER_HIT  = 4'd8,
        RESOLVE     = 4'd9,
        DONE        = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE   = 2'b00,
        RES_PLAYER = 2'b01,
        RES_DEALER = 2'b10,
        RES_PUSH   = 2'b11
    } result_t;

    // Point value of a card with the ace counted low; 0 and 11-15 are tens.
    function automatic logic [3:0] card_points(input logic [3:0] v);
        if (v == 4'd0 || v > 4'd10) begin
            return 4'd10;
        end
        return v;
    endfunction

endpackage

// File: rtl/bj_hand_accum.sv
// One hand: running total plus soft-ace flag, with the card add rule.
module bj_hand_accum
    import bj_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_add,
    input  logic [3:0]         i_card,
    output logic [SCORE_W-1:0] o_total,
    output logic [SCORE_W-1:0] o_total_next,
    output logic               o_soft
);

    localparam logic [SCORE_W-1:0] C_BJ         = SCORE_W'(BLACKJACK);
    localparam logic [SCORE_W-1:0] C_ACE_HI_MAX = SCORE_W'(BLACKJACK - 11);
    localparam logic [SCORE_W-1:0] C_TEN        = SCORE_W'(10);
    localparam logic [SCORE_W-1:0] C_ELEVEN     = SCORE_W'(11);

    logic [SCORE_W-1:0] r_total;
    logic               r_soft;
    logic [SCORE_W-1:0] w_sum;
    logic               w_sum_soft;
    logic               w_soft_next;

    // Candidate total if the presented card were added this cycle.
    always_comb begin
        w_sum      = r_total + SCORE_W'(card_points(i_card));
        w_sum_soft = r_soft;
        if (i_card == 4'(ACE) && r_total <= C_ACE_HI_MAX) begin
            w_sum      = r_total + C_ELEVEN;
            w_sum_soft = 1'b1;
        end
        // A soft ace absorbs a bust by dropping back to 1.
        if (w_sum > C_BJ && w_sum_soft) begin
            w_sum      = w_sum - C_TEN;
            w_sum_soft = 1'b0;
        end
    end

    // Select next register contents: clear wins over add.
    always_comb begin
        o_total_next = r_total;
        w_soft_next  = r_soft;
        if (i_clear) begin
            o_total_next = '0;
            w_soft_next  = 1'b0;
        end else if (i_add) begin
            o_total_next = w_sum;
            w_soft_next  = w_sum_soft;
        end
    end

    // Hand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= '0;
            r_soft  <= 1'b0;
        end else begin
            r_total <= o_total_next;
            r_soft  <= w_soft_next;
        end
    end

    assign o_total = r_total;
    assign o_soft  = r_soft;

endmodule

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencing: deal, player turn, dealer draw rule, resolve.
//
// state       | meaning
// IDLE        | waiting for the first deal after reset
// DEAL_P1     | first player card
// DEAL_D1     | first dealer card
// DEAL_P2     | second player card
// DEAL_D2     | second dealer card
// PLAYER_TURN | waiting for hit or stand
// PLAYER_HIT  | fetching one player card
// DEALER_TURN | dealer draw decision
// DEALER_HIT  | fetching one dealer card
// RESOLVE     | one cycle, computes the outcome
// DONE        | outcome published until the next deal
module blackjack_round_ctrl
    import bj_pkg::*;
#(
    parameter int DEALER_STAND = 17,
    parameter int SCORE_W      = SCORE_W_DEF
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hit_pressed,
    input  logic               stand_pressed,
    input  logic               deal_pressed,
    output logic               card_req,
    output logic               card_to_dealer,
    input  logic               card_valid,
    input  logic [3:0]         card_value,
    output logic [SCORE_W-1:0] player_total,
    output logic [SCORE_W-1:0] dealer_total,
    output logic               player_soft,
    output logic               dealer_soft,
    output logic [3:0]         state,
    output logic [1:0]         result,
    output logic               result_valid,
    output logic               round_done
);

    localparam logic [SCORE_W-1:0] C_BJ    = SCORE_W'(BLACKJACK);
    localparam logic [SCORE_W-1:0] C_STAND = SCORE_W'(DEALER_STAND);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_card_req;
    logic [1:0]         r_result;
    logic               r_round_done;

    logic               w_start;
    logic               w_card_state;
    logic               w_to_dealer;
    logic               w_take;
    logic [SCORE_W-1:0] w_player_next;
    logic [SCORE_W-1:0] w_dealer_next;
    logic [SCORE_W-1:0] w_card_next;
    logic [1:0]         w_res;

    assign w_card_state = (r_state == DEAL_P1) || (r_state == DEAL_D1) ||
                          (r_state == DEAL_P2) || (r_state == DEAL_D2) ||
                          (r_state == PLAYER_HIT) || (r_state == DEALER_HIT);
    assign w_to_dealer  = (r_state == DEAL_D1) || (r_state == DEAL_D2) ||
                          (r_state == DEALER_HIT);
    // Only a card presented against an open request counts.
    assign w_take       = card_valid & r_card_req;
    // Total of the hand receiving the current card, after it is added.
    assign w_card_next  = w_to_dealer ? w_dealer_next : w_player_next;

    bj_hand_accum #(.SCORE_W(SCORE_W)) u_player (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_start),
        .i_add        (w_take & ~w_to_dealer),
        .i_card       (card_value),
        .o_total      (player_total),
        .o_total_next (w_player_next),
        .o_soft       (player_soft)
    );

    bj_hand_accum #(.SCORE_W(SCORE_W)) u_dealer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_start),
        .i_add        (w_take & w_to_dealer),
        .i_card       (card_value),
        .o_total      (dealer_total),
        .o_total_next (w_dealer_next),
        .o_soft       (dealer_soft)
    );

    // Next-state logic; w_start marks the cycle a new round is accepted.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (deal_pressed) begin
                    w_state_next = DEAL_P1;
                    w_start      = 1'b1;
                end
            end
            DEAL_P1: if (w_take) w_state_next = DEAL_D1;
            DEAL_D1: if (w_take) w_state_next = DEAL_P2;
            DEAL_P2: if (w_take) w_state_next = DEAL_D2;
            DEAL_D2: begin
                if (w_take) begin
                    w_state_next = (player_total == C_BJ) ? DEALER_TURN : PLAYER_TURN;
                end
            end
            PLAYER_TURN: begin
                if (stand_pressed) begin
                    w_state_next = DEALER_TURN;
                end else if (hit_pressed) begin
                    w_state_next = PLAYER_HIT;
                end
            end
            PLAYER_HIT: begin
                if (w_take) begin
                    if (w_card_next > C_BJ) begin
                        w_state_next = RESOLVE;
                    end else if (w_card_next == C_BJ) begin
                        w_state_next = DEALER_TURN;
                    end else begin
                        w_state_next = PLAYER_TURN;
                    end
                end
            end
            DEALER_TURN: begin
                w_state_next = (dealer_total < C_STAND) ? DEALER_HIT : RESOLVE;
            end
            DEALER_HIT: if (w_take) w_state_next = DEALER_TURN;
            RESOLVE:    w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    // Round outcome from the settled totals.
    always_comb begin
        w_res = RES_PUSH;
        if (player_total > C_BJ) begin
            w_res = RES_DEALER;
        end else if (dealer_total > C_BJ) begin
            w_res = RES_PLAYER;
        end else if (player_total > dealer_total) begin
            w_res = RES_PLAYER;
        end else if (player_total < dealer_total) begin
            w_res = RES_DEALER;
        end
    end

    // State, card request, result and done-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_card_req   <= 1'b0;
            r_result     <= RES_NONE;
            r_round_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            // Drop for one cycle after each accepted card so one pulse adds one card.
            r_card_req   <= w_card_state & ~w_take;
            r_round_done <= (r_state == RESOLVE);
            if (w_start) begin
                r_result <= RES_NONE;
            end else if (r_state == RESOLVE) begin
                r_result <= w_res;
            end
        end
    end

    assign card_req       = r_card_req;
    assign card_to_dealer = w_to_dealer;
    assign state          = r_state;
    assign result         = r_result;
    assign result_valid   = (r_state == DONE);
    assign round_done     = r_round_done;

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Directed bench for blackjack_round_ctrl: deal table plus round sequences.
module tb_blackjack_round_ctrl;
    import bj_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hit_pressed, stand_pressed, deal_pressed;
    logic       card_req, card_to_dealer;
    logic       card_valid;
    logic [3:0] card_value;
    logic [4:0] player_total, dealer_total;
    logic       player_soft, dealer_soft;
    logic [3:0] state;
    logic [1:0] result;
    logic       result_valid, round_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] c0, c1, c2, c3;
        int pt; int ps; int dt; int ds; int st;
    } row_t;
    row_t rows[7];

    blackjack_round_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hit_pressed    (hit_pressed),
        .stand_pressed  (stand_pressed),
        .deal_pressed   (deal_pressed),
        .card_req       (card_req),
        .card_to_dealer (card_to_dealer),
        .card_valid     (card_valid),
        .card_value     (card_value),
        .player_total   (player_total),
        .dealer_total   (dealer_total),
        .player_soft    (player_soft),
        .dealer_soft    (dealer_soft),
        .state          (state),
        .result         (result),
        .result_valid   (result_valid),
        .round_done     (round_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        hit_pressed = 0; stand_pressed = 0; deal_pressed = 0;
        card_valid = 0; card_value = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic deal();
        deal_pressed = 1;
        @(negedge clk);
        deal_pressed = 0;
    endtask

    task automatic press(input logic h, input logic s);
        hit_pressed = h; stand_pressed = s;
        @(negedge clk);
        hit_pressed = 0; stand_pressed = 0;
    endtask

    task automatic give_card(input logic [3:0] v, input int lat);
        int n = 0;
        while (card_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("card_req_rise", int'(card_req), 1);
        if (card_req === 1'b1) begin
            repeat (lat) @(negedge clk);
            card_valid = 1; card_value = v;
            @(negedge clk);
            card_valid = 0; card_value = 0;
            chk("card_req_fall", int'(card_req), 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"},   int'(state), int'(IDLE));
        chk({tag, "_req"},     int'(card_req), 0);
        chk({tag, "_todlr"},   int'(card_to_dealer), 0);
        chk({tag, "_ptot"},    int'(player_total), 0);
        chk({tag, "_dtot"},    int'(dealer_total), 0);
        chk({tag, "_psoft"},   int'(player_soft), 0);
        chk({tag, "_dsoft"},   int'(dealer_soft), 0);
        chk({tag, "_result"},  int'(result), 0);
        chk({tag, "_rvalid"},  int'(result_valid), 0);
        chk({tag, "_rdone"},   int'(round_done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int reqs;

        // deal order: c0 player, c1 dealer, c2 player, c3 dealer
        rows[0] = '{4'd10, 4'd7,  4'd9,  4'd8,  19, 0, 15, 0, int'(PLAYER_TURN)};
        rows[1] = '{4'd1,  4'd9,  4'd1,  4'd7,  12, 1, 16, 0, int'(PLAYER_TURN)};
        rows[2] = '{4'd1,  4'd10, 4'd13, 4'd7,  21, 1, 17, 0, int'(DEALER_TURN)};
        rows[3] = '{4'd0,  4'd15, 4'd5,  4'd11, 15, 0, 20, 0, int'(PLAYER_TURN)};
        rows[4] = '{4'd1,  4'd1,  4'd5,  4'd1,  16, 1, 12, 1, int'(PLAYER_TURN)};
        rows[5] = '{4'd6,  4'd1,  4'd5,  4'd6,  11, 0, 17, 1, int'(PLAYER_TURN)};
        rows[6] = '{4'd10, 4'd1,  4'd1,  4'd10, 21, 1, 21, 1, int'(DEALER_TURN)};

        do_reset();
        chk_all_zero("reset");

        for (int i = 0; i < 7; i++) begin
            do_reset();
            deal();
            give_card(rows[i].c0, i % 3);
            give_card(rows[i].c1, (i + 1) % 3);
            give_card(rows[i].c2, (i + 2) % 3);
            give_card(rows[i].c3, i % 2);
            chk($sformatf("row%0d_ptot", i),  int'(player_total), rows[i].pt);
            chk($sformatf("row%0d_psoft", i), int'(player_soft),  rows[i].ps);
            chk($sformatf("row%0d_dtot", i),  int'(dealer_total), rows[i].dt);
            chk($sformatf("row%0d_dsoft", i), int'(dealer_soft),  rows[i].ds);
            chk($sformatf("row%0d_state", i), int'(state),        rows[i].st);
        end

        // Basic round: player 19 stands, dealer 15 draws 5, dealer wins.
        do_reset();
        deal();
        chk("a_deal_state", int'(state), int'(DEAL_P1));
        chk("a_deal_req", int'(card_req), 0);
        give_card(4'd10, 0); give_card(4'd7, 1); give_card(4'd9, 0); give_card(4'd8, 2);
        press(0, 1);
        chk("a_stand_state", int'(state), int'(DEALER_TURN));
        step();
        chk("a_dhit_state", int'(state), int'(DEALER_HIT));
        chk("a_dhit_dest", int'(card_to_dealer), 1);
        give_card(4'd5, 1);
        chk("a_dtot", int'(dealer_total), 20);
        chk("a_back_dturn", int'(state), int'(DEALER_TURN));
        step();
        chk("a_resolve", int'(state), int'(RESOLVE));
        chk("a_resolve_rv", int'(result_valid), 0);
        step();
        chk("a_done", int'(state), int'(DONE));
        chk("a_result", int'(result), 2);
        chk("a_rvalid", int'(result_valid), 1);
        chk("a_rdone_1", int'(round_done), 1);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (round_done === 1'b1) pulses++;
        end
        chk("a_rdone_extra", pulses, 0);
        chk("a_result_hold", int'(result), 2);
        chk("a_rvalid_hold", int'(result_valid), 1);
        // New deal from DONE clears the round.
        deal();
        chk("a_redeal_state", int'(state), int'(DEAL_P1));
        chk("a_redeal_ptot", int'(player_total), 0);
        chk("a_redeal_dtot", int'(dealer_total), 0);
        chk("a_redeal_result", int'(result), 0);
        chk("a_redeal_rvalid", int'(result_valid), 0);

        // Player busts on a hit: straight to RESOLVE, dealer never draws.
        do_reset();
        deal();
        give_card(4'd10, 0); give_card(4'd7, 0); give_card(4'd6, 0); give_card(4'd8, 0);
        press(1, 0);
        chk("b_hit_state", int'(state), int'(PLAYER_HIT));
        give_card(4'd10, 2);
        chk("b_ptot", int'(player_total), 26);
        chk("b_resolve", int'(state), int'(RESOLVE));
        reqs = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) chk("b_result", int'(result), 2);
            if (card_req === 1'b1) reqs++;
        end
        chk("b_no_dealer_req", reqs, 0);
        chk("b_dtot", int'(dealer_total), 15);

        // Natural 21: no stand needed, dealer 17 stands, player wins.
        do_reset();
        deal();
        give_card(4'd1, 0); give_card(4'd10, 0); give_card(4'd13, 0); give_card(4'd7, 0);
        chk("c_dturn", int'(state), int'(DEALER_TURN));
        step();
        chk("c_resolve", int'(state), int'(RESOLVE));
        step();
        chk("c_result", int'(result), 1);

        // Hit and stand together: stand wins; dealer draws 2 to 17, player 19 wins.
        do_reset();
        deal();
        give_card(4'd10, 0); give_card(4'd7, 0); give_card(4'd9, 0); give_card(4'd8, 0);
        press(1, 1);
        chk("d_both_state", int'(state), int'(DEALER_TURN));
        step();
        give_card(4'd2, 0);
        chk("d_dtot", int'(dealer_total), 17);
        step();
        step();
        chk("d_result", int'(result), 1);

        // Stray card_valid and mid-round deal are ignored.
        do_reset();
        deal();
        card_valid = 1; card_value = 4'd5;
        step();
        card_valid = 0; card_value = 0;
        chk("e_stray_req", int'(card_req), 1);
        chk("e_stray_ptot", int'(player_total), 0);
        give_card(4'd10, 0); give_card(4'd7, 0); give_card(4'd9, 0); give_card(4'd8, 0);
        card_valid = 1; card_value = 4'd10;
        step();
        card_valid = 0; card_value = 0;
        chk("e_turn_ptot", int'(player_total), 19);
        chk("e_turn_dtot", int'(dealer_total), 15);
        deal();
        chk("e_middeal_state", int'(state), int'(PLAYER_TURN));
        chk("e_middeal_ptot", int'(player_total), 19);

        // Reset asserted during DEAL_P2 with the request pending.
        do_reset();
        deal();
        give_card(4'd10, 0); give_card(4'd7, 0);
        step();
        chk("f_p2_state", int'(state), int'(DEAL_P2));
        chk("f_p2_req", int'(card_req), 1);
        #2 rst_n = 0;
        #1;
        chk_all_zero("f_async");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Dealer stands on soft 17; 17 vs 17 is a push.
        do_reset();
        deal();
        give_card(4'd10, 0); give_card(4'd1, 0); give_card(4'd7, 0); give_card(4'd6, 0);
        chk("g_dsoft", int'(dealer_soft), 1);
        press(0, 1);
        step();
        chk("g_soft17_stand", int'(state), int'(RESOLVE));
        step();
        chk("g_push", int'(result), 3);

        // Soft hand absorbs a bust, then a hit to exactly 21 passes to dealer.
        do_reset();
        deal();
        give_card(4'd1, 0); give_card(4'd10, 0); give_card(4'd5, 0); give_card(4'd8, 0);
        press(1, 0);
        give_card(4'd10, 1);
        chk("h_ptot16", int'(player_total), 16);
        chk("h_hard", int'(player_soft), 0);
        chk("h_turn", int'(state), int'(PLAYER_TURN));
        press(1, 0);
        give_card(4'd5, 0);
        chk("h_ptot21", int'(player_total), 21);
        chk("h_dturn", int'(state), int'(DEALER_TURN));
        step();
        step();
        chk("h_result", int'(result), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
